// File: rtl/wb_regfile_ctl.sv
// Y86-64 write-back stage: dual-write register file, bypassed reads,
// sticky processor status and retired-instruction counter.
module wb_regfile_ctl #(
  parameter int                DATA_W  = 64,
  parameter int                NREG    = 15,
  parameter int                ADDR_W  = 4,
  parameter int                SP_IDX  = 4,
  parameter logic [DATA_W-1:0] SP_INIT = 'h100,
  parameter int                CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   W_stall,
  input  logic [2:0]             W_stat,
  input  logic [3:0]             W_icode,
  input  logic [DATA_W-1:0]      W_valE,
  input  logic [DATA_W-1:0]      W_valM,
  input  logic [ADDR_W-1:0]      W_dstE,
  input  logic [ADDR_W-1:0]      W_dstM,
  input  logic [ADDR_W-1:0]      srcA,
  input  logic [ADDR_W-1:0]      srcB,
  output logic [DATA_W-1:0]      valA,
  output logic [DATA_W-1:0]      valB,
  output logic [2:0]             stat,
  output logic                   halted,
  output logic [CNT_W-1:0]       retired,
  output logic [NREG*DATA_W-1:0] regs_flat
);

  typedef enum logic {RUN, HALTED} state_e;

  localparam logic [2:0]        S_AOK   = 3'd1;
  localparam logic [2:0]        S_HLT   = 3'd2;
  localparam logic [ADDR_W-1:0] R_NONE  = '1;
  localparam logic [ADDR_W-1:0] NREG_ID = ADDR_W'(NREG);

  state_e            state_q;
  logic [2:0]        stat_q;
  logic [CNT_W-1:0]  retired_q;
  logic [CNT_W-1:0]  retired_d;
  logic [DATA_W-1:0] regs_q [NREG];

  logic commit, wr_ok, we_e, we_m, count;

  assign commit = (state_q == RUN) && !W_stall;
  assign wr_ok  = commit && (W_stat == S_AOK);
  assign we_e   = wr_ok && (W_dstE != R_NONE) && (W_dstE < NREG_ID);
  assign we_m   = wr_ok && (W_dstM != R_NONE) && (W_dstM < NREG_ID);
  assign count  = commit && (W_icode != 4'h1) &&
                  ((W_stat == S_AOK) || (W_stat == S_HLT));

  assign retired_d = count ? retired_q + 1'b1 : retired_q;

  // Same-cycle bypass: M beats E, both only when the write really commits.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    if (id != R_NONE && id < NREG_ID) begin
      if (we_m && W_dstM == id)      v = W_valM;
      else if (we_e && W_dstE == id) v = W_valE;
      else                           v = regs_q[id];
    end
    return v;
  endfunction

  assign valA = rd(srcA);
  assign valB = rd(srcB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      stat_q    <= S_AOK;
      retired_q <= '0;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else begin
      retired_q <= retired_d;
      if (commit && W_stat != S_AOK) begin
        stat_q  <= W_stat;
        state_q <= HALTED;
      end
      if (we_e) regs_q[W_dstE] <= W_valE;
      if (we_m) regs_q[W_dstM] <= W_valM;
    end
  end

  assign stat    = stat_q;
  assign halted  = (state_q == HALTED);
  assign retired = retired_q;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_wb_regfile_ctl.sv
// Directed bench for wb_regfile_ctl: default build plus a NREG=14,
// CNT_W=4 build sharing the same stimulus.
module tb_wb_regfile_ctl;

  logic        clk = 0;
  logic        rst;
  logic        W_stall;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM, srcA, srcB;

  logic [63:0]  valA, valB, valA2, valB2;
  logic [2:0]   stat, stat2;
  logic         halted, halted2;
  logic [31:0]  retired;
  logic [3:0]   retired2;
  logic [959:0] flat;
  logic [895:0] flat2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_regfile_ctl dut (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_stat(W_stat),
    .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .stat(stat), .halted(halted),
    .retired(retired), .regs_flat(flat)
  );

  wb_regfile_ctl #(.NREG(14), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_stat(W_stat),
    .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .srcA(srcA), .srcB(srcB),
    .valA(valA2), .valB(valB2), .stat(stat2), .halted(halted2),
    .retired(retired2), .regs_flat(flat2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkf(input string tag, input logic [959:0] obs,
                      input logic [959:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    W_stall = 0; W_stat = 3'd1; W_icode = 4'h1;
    W_valE = '0; W_valM = '0; W_dstE = 4'hF; W_dstM = 4'hF;
  endtask

  task automatic wr(input logic [2:0] st, input logic [3:0] ic,
                    input logic [3:0] de, input logic [63:0] ve,
                    input logic [3:0] dm, input logic [63:0] vm);
    W_stall = 0; W_stat = st; W_icode = ic;
    W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    rst = 0;
    tick();
  endtask

  logic [959:0] exp_flat;

  initial begin
    idle();
    srcA = 4'h4; srcB = 4'hF;
    rst = 1;
    tick(); tick();

    exp_flat = '0;
    exp_flat[4*64 +: 64] = 64'h100;
    chkf("rst_regs", flat, exp_flat);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_valA_sp", valA, 64'h100);
    chk("rst_valB_none", valB, 64'd0);
    rst = 0;
    tick();

    wr(3'd1, 4'h5, 4'd3, 64'hAA, 4'd3, 64'hBB);
    srcA = 4'd3;
    #1 chk("dual_bypass_M", valA, 64'hBB);
    tick(); idle();
    chk("dual_reg3", flat[3*64 +: 64], 64'hBB);
    chk("dual_retired", 64'(retired), 64'd1);

    wr(3'd1, 4'h6, 4'd2, 64'h55, 4'hF, 64'h0);
    W_stall = 1; srcA = 4'd2;
    #1 chk("stall_no_bypass", valA, 64'd0);
    tick();
    chk("stall_reg2", flat[2*64 +: 64], 64'd0);
    chk("stall_retired", 64'(retired), 64'd1);
    W_stall = 0;
    #1 chk("bypass_E", valA, 64'h55);
    tick(); idle();
    srcB = 4'd2;
    #1 chk("reg2_valB", valB, 64'h55);
    chk("bypass_retired", 64'(retired), 64'd2);

    wr(3'd1, 4'h5, 4'hE, 64'h123, 4'hF, 64'h0);
    srcA = 4'hE;
    #1 chk("range_valA_n15", valA, 64'h123);
    chk("range_valA_n14", valA2, 64'd0);
    tick(); idle();
    exp_flat = '0;
    exp_flat[4*64 +: 64] = 64'h100;
    exp_flat[3*64 +: 64] = 64'hBB;
    exp_flat[2*64 +: 64] = 64'h55;
    chkf("range_regs_n14", 960'(flat2), exp_flat);
    chk("range_read_n14", valA2, 64'd0);
    chk("range_reg14_n15", flat[14*64 +: 64], 64'h123);
    chk("range_retired2", 64'(retired2), 64'd3);

    tick();
    chk("bubble_not_counted", 64'(retired), 64'd3);
    for (int i = 0; i < 13; i++) begin
      wr(3'd1, 4'h5, 4'hF, 64'h0, 4'hF, 64'h0);
      tick();
    end
    idle();
    chk("wrap_retired2", 64'(retired2), 64'd0);
    chk("wrap_retired", 64'(retired), 64'd16);

    wr(3'd3, 4'h5, 4'd1, 64'h77, 4'hF, 64'h0);
    srcA = 4'd1;
    #1 chk("fault_no_bypass", valA, 64'd0);
    tick();
    wr(3'd1, 4'h5, 4'd0, 64'h9, 4'hF, 64'h0);
    srcA = 4'd0;
    chk("fault_stat", 64'(stat), 64'd3);
    chk("fault_halted", 64'(halted), 64'd1);
    chk("fault_retired", 64'(retired), 64'd16);
    chk("fault_reg1", flat[1*64 +: 64], 64'd0);
    #1 chk("halt_no_bypass", valA, 64'd0);
    tick(); idle();
    chk("halt_reg0", flat[0*64 +: 64], 64'd0);
    chk("halt_retired", 64'(retired), 64'd16);
    chk("halt_stat_held", 64'(stat), 64'd3);

    do_reset();
    chk("rst2_stat", 64'(stat), 64'd1);
    chk("rst2_halted", 64'(halted), 64'd0);
    chk("rst2_retired", 64'(retired), 64'd0);
    chk("rst2_reg3", flat[3*64 +: 64], 64'd0);

    wr(3'd2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    wr(3'd4, 4'h5, 4'd5, 64'h33, 4'hF, 64'h0);
    chk("hlt_retired", 64'(retired), 64'd1);
    chk("hlt_stat", 64'(stat), 64'd2);
    chk("hlt_halted", 64'(halted), 64'd1);
    tick(); idle();
    chk("hlt_sticky_stat", 64'(stat), 64'd2);
    chk("hlt_sticky_reg5", flat[5*64 +: 64], 64'd0);
    chk("hlt_sticky_retired", 64'(retired), 64'd1);

    do_reset();
    chk("rst3_stat", 64'(stat), 64'd1);
    chk("rst3_halted", 64'(halted), 64'd0);
    chk("rst3_retired", 64'(retired), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile_ctl.md
# wb_regfile_ctl

Parameterised write-back stage and register file for the pipelined Y86-64 core. It sits after the memory stage and the W pipeline register. It commits valE/valM to a NREG-entry register file with two write ports and M-over-E priority. It serves two decode read ports with same-cycle write bypass, and latches a sticky processor status that freezes architectural state on the first non-AOK instruction. It also counts retired instructions and exports a flattened register dump for the bench.

## Interface
- DATA_W, 64, register and value width
- NREG, 15, number of architectural registers (indices 0..NREG-1; NREG ≤ 15)
- ADDR_W, 4, register-id width; id 4'hF means "no register"
- SP_IDX, 4, index of %rsp
- SP_INIT, 64'h100, reset value of register SP_IDX; all other registers reset to 0
- CNT_W, 32, retired-counter width

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- W_stall  in  1  W slot not valid this cycle; no commit, no count, no status update
- W_stat  in  3  status of W instruction (1 AOK, 2 HLT, 3 ADR, 4 INS)
- W_icode  in  4  icode of W instruction
- W_valE, W_valM  in  DATA_W  write data
- W_dstE, W_dstM  in  ADDR_W  destination ids (4'hF = none)
- srcA, srcB  in  ADDR_W  decode read ids
- valA, valB  out  DATA_W  read data (combinational, bypassed)
- stat  out  3  latched processor status
- halted  out  1  1 when in HALTED state
- retired  out  CNT_W  retired-instruction count
- regs_flat  out  NREG*DATA_W  register i at bits [i*DATA_W +: DATA_W], registered contents only

## Operation
- Two states: RUN, HALTED. Reset enters RUN.
- Commit cycle = RUN and W_stall=0.
- On a commit cycle with W_stat=AOK:
  - write W_valE to W_dstE if W_dstE≠F and W_dstE<NREG
  - write W_valM to W_dstM under the same rule
  - if W_dstE=W_dstM (valid), W_valM wins
- On a commit cycle with W_stat≠AOK:
  - no register writes
  - stat ← W_stat
  - next state HALTED
- HALTED is sticky until rst: no writes; W_* and W_stall are ignored; stat is held.
- retired increments by 1 on a commit cycle when W_icode≠4'h1 (nop/bubble) and W_stat ∈ {AOK, HLT}.
  - ADR/INS are not counted.
  - The counter wraps modulo 2^CNT_W.
- Reads, per port:
  - id=F or id≥NREG → 0
  - else if the current cycle commits a write to that id → the bypassed value, with M over E priority
  - else the register contents
- Bypass is gated off when HALTED, W_stall=1, or W_stat≠AOK.
- Out-of-range write ids (NREG..14) are silently dropped; no other register is disturbed.

## Timing
- Reset (async, immediate):
  - regs = 0 except reg[SP_IDX]=SP_INIT
  - stat=1
  - halted=0
  - retired=0
  - valA/valB reflect the reset contents
- Write latency: a value written at edge N is in regs_flat after edge N. valA/valB see it in the same cycle as the commit via bypass (zero-cycle read-after-write).
- stat/halted update at the edge ending the faulting commit cycle. An instruction arriving in the following cycle is already blocked.
- Simultaneous fault and dst writes in one cycle: the fault wins, and nothing is written.
- rst asserted mid-operation overrides any in-flight commit. Deassertion is sampled at the next rising edge.
- No combinational path from W_* to stat/halted/retired; these are registered only. valA/valB are the only combinational outputs.

## Test plan
- Reset: pulse rst → reg4=0x100, all others 0, stat=1, halted=0, retired=0; srcA=4 gives valA=0x100.
- Dual write, same id: W_dstE=W_dstM=3, valE=0xAA, valM=0xBB, icode=5, AOK → valA(srcA=3)=0xBB in the same cycle; reg3=0xBB after the edge; retired=1.
- Bypass/stall:
  - W_dstE=2, valE=0x55, W_stall=1 → valA(srcA=2)=0 and reg2 unchanged.
  - Same with W_stall=0 → valA=0x55 in the same cycle.
- Fault: W_stat=3 (ADR), W_dstE=1, valE=0x77 → reg1 unchanged, stat=3, halted=1, retired unchanged. A subsequent AOK write to reg0=0x9 is ignored.
- Halt counting: icode=0, W_stat=2 → retired+1, stat=2, halted=1. Then rst → RUN, stat=1, counters cleared.
- Range/wrap:
  - Write to id 0xE with NREG=14 → no register changes; read of 0xE returns 0.
  - Preload retired=2^CNT_W−1 with CNT_W=4, commit 1 → retired=0.
